// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants: tag geometry, RV32 opcodes, datapath widths
// and the op-class encoding used by the ROB, RS, LSB and register file.
package rob_pkg;

   localparam int unsigned TAG_W    = 4;
   localparam int unsigned ROB_SIZE = 15;

   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned INST_W   = 32;
   localparam int unsigned REGVAL_W = 32;
   localparam int unsigned REG_W    = 5;

   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      OpOther,
      OpStore,
      OpLoad,
      OpBranch,
      OpJal,
      OpJalr
   } op_class_e;

   // Control-flow ops are the only ones whose resolved npc can disagree with the prediction.
   function automatic logic is_ctrl(input op_class_e op);
      return (op == OpBranch) || (op == OpJal) || (op == OpJalr);
   endfunction

   function automatic logic writes_rd(input op_class_e op);
      return (op != OpStore) && (op != OpBranch);
   endfunction

endpackage

// File: rtl/rob_op_class.sv
// Decodes the major opcode of a dispatched instruction into the ROB op class.
module rob_op_class
   import rob_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [2:0] op_class_o
);

   op_class_e cls;

   always_comb begin
      cls = OpOther;
      unique case (opcode_i)
         OPC_STORE:  cls = OpStore;
         OPC_LOAD:   cls = OpLoad;
         OPC_BRANCH: cls = OpBranch;
         OPC_JAL:    cls = OpJal;
         OPC_JALR:   cls = OpJalr;
         default:    cls = OpOther;
      endcase
   end

   assign op_class_o = cls;

endmodule

// File: rtl/reorder_buffer.sv
// In-order commit reorder buffer: circular FIFO over tags 1..ROB_SIZE with operand
// forwarding, store/load head handshakes and mispredict flush.
module reorder_buffer #(
   parameter int unsigned TAG_W       = 4,
   parameter int unsigned ROB_SIZE    = 15,
   parameter int unsigned FULL_MARGIN = 2
) (
   input  logic                           clk_in,
   input  logic                           rst_in,
   input  logic                           rdy_in,
   input  logic                           dispatch_rdy,
   input  logic [rob_pkg::INST_W-1:0]     up_inst,
   input  logic [rob_pkg::ADDR_W-1:0]     up_npc,
   input  logic [rob_pkg::REG_W-1:0]      up_rd,
   input  logic [TAG_W-1:0]               rs1_rely,
   input  logic [TAG_W-1:0]               rs2_rely,
   input  logic                           rs_rdy,
   input  logic [TAG_W-1:0]               rs_tag_bus,
   input  logic [rob_pkg::REGVAL_W-1:0]   up_alu_output,
   input  logic [rob_pkg::ADDR_W-1:0]     alu_npc,
   input  logic                           lsb_rdy,
   input  logic [TAG_W-1:0]               lsb_tag_bus,
   input  logic [rob_pkg::REGVAL_W-1:0]   up_lmd_output,
   output logic [TAG_W-1:0]               ROB_next_tag,
   output logic                           ROB_FULL,
   output logic                           ROB_rs1_valid,
   output logic                           ROB_rs2_valid,
   output logic [rob_pkg::REGVAL_W-1:0]   ROB_rs1_ans_output,
   output logic [rob_pkg::REGVAL_W-1:0]   ROB_rs2_ans_output,
   output logic                           enable_write,
   output logic                           enable_IO,
   output logic                           write_rdy,
   output logic [rob_pkg::REGVAL_W-1:0]   write_val,
   output logic [rob_pkg::REG_W-1:0]      to_rd,
   output logic [TAG_W-1:0]               head_tag,
   output logic                           commit_pulse,
   output logic                           clear,
   output logic [rob_pkg::ADDR_W-1:0]     to_pc
);

   import rob_pkg::*;

   localparam int unsigned CNT_W = TAG_W + 1;
   localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
   localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE);
   localparam logic [CNT_W-1:0] SIZE_CNT  = CNT_W'(ROB_SIZE);
   localparam logic [CNT_W-1:0] FULL_LVL  = CNT_W'(ROB_SIZE - FULL_MARGIN);

   logic [ROB_SIZE:1]   busy_q, busy_d, ready_q, ready_d;
   op_class_e           op_q   [1:ROB_SIZE];
   op_class_e           op_d   [1:ROB_SIZE];
   logic [REG_W-1:0]    rd_q   [1:ROB_SIZE];
   logic [REG_W-1:0]    rd_d   [1:ROB_SIZE];
   logic [ADDR_W-1:0]   pnpc_q [1:ROB_SIZE];
   logic [ADDR_W-1:0]   pnpc_d [1:ROB_SIZE];
   logic [REGVAL_W-1:0] val_q  [1:ROB_SIZE];
   logic [REGVAL_W-1:0] val_d  [1:ROB_SIZE];
   logic [ADDR_W-1:0]   anpc_q [1:ROB_SIZE];
   logic [ADDR_W-1:0]   anpc_d [1:ROB_SIZE];

   logic [TAG_W-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]    count_q, count_d;

   logic                write_rdy_q, write_rdy_d, commit_pulse_q, commit_pulse_d;
   logic                clear_q, clear_d;
   logic [REGVAL_W-1:0] write_val_q, write_val_d;
   logic [REG_W-1:0]    to_rd_q, to_rd_d;
   logic [TAG_W-1:0]    head_tag_q, head_tag_d;
   logic [ADDR_W-1:0]   to_pc_q, to_pc_d;

   logic [2:0]          disp_cls;
   op_class_e           disp_op, head_op;
   logic                do_commit, do_disp, mispredict;
   logic [REGVAL_W:0]   fwd1, fwd2;
   logic                unused_inst;

   assign unused_inst = ^up_inst[INST_W-1:7];

   rob_op_class u_op_class (
      .opcode_i   (up_inst[6:0]),
      .op_class_o (disp_cls)
   );

   assign disp_op = op_class_e'(disp_cls);
   assign head_op = op_q[head_q];

   function automatic logic [TAG_W-1:0] inc_ptr(input logic [TAG_W-1:0] p);
      return (p == LAST_TAG) ? FIRST_TAG : p + FIRST_TAG;
   endfunction

   function automatic logic tag_ok(input logic [TAG_W-1:0] t);
      return (t != '0) && (t <= LAST_TAG);
   endfunction

   // Same-cycle result buses take priority over the stored entry value.
   function automatic logic [REGVAL_W:0] fwd(input logic [TAG_W-1:0] rely);
      if (!tag_ok(rely)) return '0;
      if (rs_rdy && (rs_tag_bus == rely)) return {1'b1, up_alu_output};
      if (lsb_rdy && (lsb_tag_bus == rely)) return {1'b1, up_lmd_output};
      if (busy_q[rely] && ready_q[rely]) return {1'b1, val_q[rely]};
      return '0;
   endfunction

   always_comb begin
      fwd1 = fwd(rs1_rely);
      fwd2 = fwd(rs2_rely);
   end

   assign ROB_rs1_valid      = fwd1[REGVAL_W];
   assign ROB_rs1_ans_output = fwd1[REGVAL_W-1:0];
   assign ROB_rs2_valid      = fwd2[REGVAL_W];
   assign ROB_rs2_ans_output = fwd2[REGVAL_W-1:0];

   assign ROB_next_tag = tail_q;
   assign ROB_FULL     = (count_q >= FULL_LVL);
   assign enable_write = busy_q[head_q] && (head_op == OpStore) && !ready_q[head_q];
   assign enable_IO    = busy_q[head_q] && (head_op == OpLoad) && !ready_q[head_q];

   assign do_commit  = busy_q[head_q] && ready_q[head_q] && !clear_q;
   assign mispredict = do_commit && is_ctrl(head_op) && (anpc_q[head_q] != pnpc_q[head_q]);
   // A full FIFO may still take a dispatch into the slot the head frees this cycle.
   assign do_disp    = dispatch_rdy && !clear_q && !mispredict &&
                       ((count_q < SIZE_CNT) || do_commit);

   always_comb begin
      busy_d  = busy_q;
      ready_d = ready_q;
      op_d    = op_q;
      rd_d    = rd_q;
      pnpc_d  = pnpc_q;
      val_d   = val_q;
      anpc_d  = anpc_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(do_disp) - CNT_W'(do_commit);

      write_rdy_d    = 1'b0;
      commit_pulse_d = 1'b0;
      clear_d        = 1'b0;
      write_val_d    = write_val_q;
      to_rd_d        = to_rd_q;
      head_tag_d     = head_tag_q;
      to_pc_d        = to_pc_q;

      if (!clear_q && rs_rdy && tag_ok(rs_tag_bus) && busy_q[rs_tag_bus]) begin
         val_d[rs_tag_bus]   = up_alu_output;
         anpc_d[rs_tag_bus]  = alu_npc;
         ready_d[rs_tag_bus] = 1'b1;
      end
      if (!clear_q && lsb_rdy && tag_ok(lsb_tag_bus) && busy_q[lsb_tag_bus]) begin
         val_d[lsb_tag_bus]   = up_lmd_output;
         ready_d[lsb_tag_bus] = 1'b1;
      end

      if (do_commit) begin
         busy_d[head_q]  = 1'b0;
         ready_d[head_q] = 1'b0;
         head_d          = inc_ptr(head_q);
         commit_pulse_d  = 1'b1;
         head_tag_d      = head_q;
         to_pc_d         = is_ctrl(head_op) ? anpc_q[head_q] : pnpc_q[head_q];
         if (writes_rd(head_op) && (rd_q[head_q] != '0)) begin
            write_rdy_d = 1'b1;
            write_val_d = val_q[head_q];
            to_rd_d     = rd_q[head_q];
         end
      end

      if (do_disp) begin
         busy_d[tail_q]  = 1'b1;
         ready_d[tail_q] = 1'b0;
         op_d[tail_q]    = disp_op;
         rd_d[tail_q]    = up_rd;
         pnpc_d[tail_q]  = up_npc;
         anpc_d[tail_q]  = up_npc;
         val_d[tail_q]   = '0;
         tail_d          = inc_ptr(tail_q);
      end

      if (mispredict) begin
         busy_d  = '0;
         ready_d = '0;
         head_d  = FIRST_TAG;
         tail_d  = FIRST_TAG;
         count_d = '0;
         clear_d = 1'b1;
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q         <= '0;
         ready_q        <= '0;
         head_q         <= FIRST_TAG;
         tail_q         <= FIRST_TAG;
         count_q        <= '0;
         write_rdy_q    <= 1'b0;
         commit_pulse_q <= 1'b0;
         clear_q        <= 1'b0;
         write_val_q    <= '0;
         to_rd_q        <= '0;
         head_tag_q     <= '0;
         to_pc_q        <= '0;
         for (int i = 1; i <= ROB_SIZE; i++) begin
            op_q[i]   <= OpOther;
            rd_q[i]   <= '0;
            pnpc_q[i] <= '0;
            val_q[i]  <= '0;
            anpc_q[i] <= '0;
         end
      end else if (rdy_in) begin
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         op_q           <= op_d;
         rd_q           <= rd_d;
         pnpc_q         <= pnpc_d;
         val_q          <= val_d;
         anpc_q         <= anpc_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         write_rdy_q    <= write_rdy_d;
         commit_pulse_q <= commit_pulse_d;
         clear_q        <= clear_d;
         write_val_q    <= write_val_d;
         to_rd_q        <= to_rd_d;
         head_tag_q     <= head_tag_d;
         to_pc_q        <= to_pc_d;
      end
   end

   assign write_rdy    = write_rdy_q;
   assign write_val    = write_val_q;
   assign to_rd        = to_rd_q;
   assign head_tag     = head_tag_q;
   assign commit_pulse = commit_pulse_q;
   assign clear        = clear_q;
   assign to_pc        = to_pc_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: commit, forwarding, store/load handshakes,
// freeze, mispredict flush and full/wrap behaviour with hand-computed expectations.
module tb_reorder_buffer;

   localparam logic [6:0] OP_ADDI  = 7'b0010011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;

   logic        clk_in, rst_in, rdy_in, dispatch_rdy;
   logic [31:0] up_inst, up_npc;
   logic [4:0]  up_rd;
   logic [3:0]  rs1_rely, rs2_rely, rs_tag_bus, lsb_tag_bus;
   logic        rs_rdy, lsb_rdy;
   logic [31:0] up_alu_output, alu_npc, up_lmd_output;
   logic [3:0]  ROB_next_tag, head_tag;
   logic        ROB_FULL, ROB_rs1_valid, ROB_rs2_valid;
   logic [31:0] ROB_rs1_ans_output, ROB_rs2_ans_output;
   logic        enable_write, enable_IO, write_rdy, commit_pulse, clear;
   logic [31:0] write_val, to_pc;
   logic [4:0]  to_rd;

   int unsigned checks = 0;
   int unsigned passes = 0;

   reorder_buffer #(.TAG_W(4), .ROB_SIZE(15), .FULL_MARGIN(2)) dut (
      .clk_in             (clk_in),
      .rst_in             (rst_in),
      .rdy_in             (rdy_in),
      .dispatch_rdy       (dispatch_rdy),
      .up_inst            (up_inst),
      .up_npc             (up_npc),
      .up_rd              (up_rd),
      .rs1_rely           (rs1_rely),
      .rs2_rely           (rs2_rely),
      .rs_rdy             (rs_rdy),
      .rs_tag_bus         (rs_tag_bus),
      .up_alu_output      (up_alu_output),
      .alu_npc            (alu_npc),
      .lsb_rdy            (lsb_rdy),
      .lsb_tag_bus        (lsb_tag_bus),
      .up_lmd_output      (up_lmd_output),
      .ROB_next_tag       (ROB_next_tag),
      .ROB_FULL           (ROB_FULL),
      .ROB_rs1_valid      (ROB_rs1_valid),
      .ROB_rs2_valid      (ROB_rs2_valid),
      .ROB_rs1_ans_output (ROB_rs1_ans_output),
      .ROB_rs2_ans_output (ROB_rs2_ans_output),
      .enable_write       (enable_write),
      .enable_IO          (enable_IO),
      .write_rdy          (write_rdy),
      .write_val          (write_val),
      .to_rd              (to_rd),
      .head_tag           (head_tag),
      .commit_pulse       (commit_pulse),
      .clear              (clear),
      .to_pc              (to_pc)
   );

   initial begin
      clk_in = 1'b0;
      forever #5 clk_in = ~clk_in;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic idle_inputs();
      dispatch_rdy  = 1'b0;
      up_inst       = 32'h0;
      up_npc        = 32'h0;
      up_rd         = 5'd0;
      rs1_rely      = 4'd0;
      rs2_rely      = 4'd0;
      rs_rdy        = 1'b0;
      rs_tag_bus    = 4'd0;
      up_alu_output = 32'h0;
      alu_npc       = 32'h0;
      lsb_rdy       = 1'b0;
      lsb_tag_bus   = 4'd0;
      up_lmd_output = 32'h0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic set_dispatch(input logic [6:0] opc, input logic [4:0] rd,
                               input logic [31:0] npc);
      dispatch_rdy = 1'b1;
      up_inst      = {25'h0a5f3, opc};
      up_rd        = rd;
      up_npc       = npc;
   endtask

   task automatic dispatch(input logic [6:0] opc, input logic [4:0] rd, input logic [31:0] npc);
      set_dispatch(opc, rd, npc);
      tick();
      dispatch_rdy = 1'b0;
   endtask

   task automatic alu_wb(input logic [3:0] tag, input logic [31:0] val, input logic [31:0] npc);
      rs_rdy        = 1'b1;
      rs_tag_bus    = tag;
      up_alu_output = val;
      alu_npc       = npc;
   endtask

   task automatic lsb_wb(input logic [3:0] tag, input logic [31:0] val);
      lsb_rdy       = 1'b1;
      lsb_tag_bus   = tag;
      up_lmd_output = val;
   endtask

   initial begin
      idle_inputs();
      rdy_in = 1'b1;
      rst_in = 1'b1;
      #2 rst_in = 1'b0;
      #1;
      chk("rst_next_tag", 32'(ROB_next_tag), 32'd1);
      chk("rst_full", 32'(ROB_FULL), 32'd0);
      chk("rst_commit", 32'(commit_pulse), 32'd0);
      chk("rst_write_rdy", 32'(write_rdy), 32'd0);
      chk("rst_clear", 32'(clear), 32'd0);
      chk("rst_to_pc", to_pc, 32'h0);
      chk("rst_en_write", 32'(enable_write), 32'd0);
      tick();
      tick();
      rst_in = 1'b1;

      // ADDI rd=5 on tag 1, ALU result 7
      dispatch(OP_ADDI, 5'd5, 32'h104);
      chk("addi_next_tag", 32'(ROB_next_tag), 32'd2);
      alu_wb(4'd1, 32'd7, 32'h104);
      rs1_rely = 4'd1;
      #1;
      chk("addi_fwd_bus_valid", 32'(ROB_rs1_valid), 32'd1);
      chk("addi_fwd_bus_val", ROB_rs1_ans_output, 32'd7);
      tick();
      idle_inputs();
      rs1_rely = 4'd1;
      #1;
      chk("addi_no_commit_yet", 32'(commit_pulse), 32'd0);
      chk("addi_fwd_entry_val", ROB_rs1_ans_output, 32'd7);
      rs1_rely = 4'd0;
      tick();
      chk("addi_write_rdy", 32'(write_rdy), 32'd1);
      chk("addi_to_rd", 32'(to_rd), 32'd5);
      chk("addi_write_val", write_val, 32'd7);
      chk("addi_head_tag", 32'(head_tag), 32'd1);
      chk("addi_commit", 32'(commit_pulse), 32'd1);
      chk("addi_to_pc", to_pc, 32'h104);
      tick();
      chk("addi_pulse_drop", 32'(commit_pulse), 32'd0);
      chk("addi_wr_drop", 32'(write_rdy), 32'd0);

      // Forwarding: tags 2 (rd 6) and 3 (rd 7)
      dispatch(OP_ADDI, 5'd6, 32'h108);
      dispatch(OP_ADDI, 5'd7, 32'h10c);
      chk("fwd_next_tag", 32'(ROB_next_tag), 32'd4);
      rs1_rely = 4'd3;
      rs2_rely = 4'd2;
      alu_wb(4'd3, 32'h55, 32'h10c);
      #1;
      chk("fwd_rs1_valid", 32'(ROB_rs1_valid), 32'd1);
      chk("fwd_rs1_val", ROB_rs1_ans_output, 32'h55);
      chk("fwd_rs2_not_ready", 32'(ROB_rs2_valid), 32'd0);
      tick();
      idle_inputs();
      rs2_rely = 4'd3;
      #1;
      chk("fwd_rely0_invalid", 32'(ROB_rs1_valid), 32'd0);
      chk("fwd_rs2_entry_valid", 32'(ROB_rs2_valid), 32'd1);
      chk("fwd_rs2_entry_val", ROB_rs2_ans_output, 32'h55);
      rs1_rely = 4'd2;
      lsb_wb(4'd2, 32'h99);
      #1;
      chk("fwd_lsb_valid", 32'(ROB_rs1_valid), 32'd1);
      chk("fwd_lsb_val", ROB_rs1_ans_output, 32'h99);
      tick();
      idle_inputs();
      tick();
      chk("fwd_c2_tag", 32'(head_tag), 32'd2);
      chk("fwd_c2_rd", 32'(to_rd), 32'd6);
      chk("fwd_c2_val", write_val, 32'h99);
      tick();
      chk("fwd_c3_tag", 32'(head_tag), 32'd3);
      chk("fwd_c3_val", write_val, 32'h55);
      chk("fwd_c3_pc", to_pc, 32'h10c);

      // Store at head (tag 4), then load (tag 5)
      dispatch(OP_STORE, 5'd3, 32'h110);
      chk("st_en_write", 32'(enable_write), 32'd1);
      chk("st_en_io", 32'(enable_IO), 32'd0);
      tick();
      chk("st_en_write_hold", 32'(enable_write), 32'd1);
      lsb_wb(4'd4, 32'h0);
      tick();
      idle_inputs();
      chk("st_en_write_done", 32'(enable_write), 32'd0);
      tick();
      chk("st_commit", 32'(commit_pulse), 32'd1);
      chk("st_head_tag", 32'(head_tag), 32'd4);
      chk("st_no_write", 32'(write_rdy), 32'd0);
      dispatch(OP_LOAD, 5'd8, 32'h114);
      chk("ld_en_io", 32'(enable_IO), 32'd1);
      chk("ld_en_write", 32'(enable_write), 32'd0);
      lsb_wb(4'd5, 32'habcd);
      tick();
      idle_inputs();
      chk("ld_en_io_done", 32'(enable_IO), 32'd0);
      tick();
      chk("ld_write_rdy", 32'(write_rdy), 32'd1);
      chk("ld_to_rd", 32'(to_rd), 32'd8);
      chk("ld_write_val", write_val, 32'habcd);

      // Freeze with a ready head (tag 6)
      dispatch(OP_ADDI, 5'd9, 32'h118);
      alu_wb(4'd6, 32'h11, 32'h118);
      tick();
      idle_inputs();
      rdy_in = 1'b0;
      set_dispatch(OP_ADDI, 5'd9, 32'h11c);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("frz_no_commit", 32'(commit_pulse), 32'd0);
         chk("frz_next_tag", 32'(ROB_next_tag), 32'd7);
      end
      dispatch_rdy = 1'b0;
      rdy_in = 1'b1;
      tick();
      chk("frz_commit", 32'(commit_pulse), 32'd1);
      chk("frz_head_tag", 32'(head_tag), 32'd6);
      chk("frz_write_val", write_val, 32'h11);

      // Mispredicted branch on tag 7 with younger tags 8, 9
      dispatch(OP_BR, 5'd0, 32'h104);
      dispatch(OP_ADDI, 5'd4, 32'h108);
      dispatch(OP_ADDI, 5'd4, 32'h10c);
      chk("br_next_tag", 32'(ROB_next_tag), 32'd10);
      alu_wb(4'd7, 32'h0, 32'h200);
      tick();
      idle_inputs();
      tick();
      chk("br_clear", 32'(clear), 32'd1);
      chk("br_to_pc", to_pc, 32'h200);
      chk("br_commit", 32'(commit_pulse), 32'd1);
      chk("br_head_tag", 32'(head_tag), 32'd7);
      chk("br_no_write", 32'(write_rdy), 32'd0);
      chk("br_next_tag_reset", 32'(ROB_next_tag), 32'd1);
      set_dispatch(OP_ADDI, 5'd4, 32'h204);
      alu_wb(4'd8, 32'h77, 32'h10c);
      tick();
      idle_inputs();
      chk("br_clear_drop", 32'(clear), 32'd0);
      chk("br_dispatch_ignored", 32'(ROB_next_tag), 32'd1);
      chk("br_no_younger_commit", 32'(commit_pulse), 32'd0);

      // Correctly predicted JAL on tag 1 writes its link
      dispatch(OP_JAL, 5'd1, 32'h300);
      alu_wb(4'd1, 32'h1004, 32'h300);
      tick();
      idle_inputs();
      tick();
      chk("jal_write_rdy", 32'(write_rdy), 32'd1);
      chk("jal_to_rd", 32'(to_rd), 32'd1);
      chk("jal_write_val", write_val, 32'h1004);
      chk("jal_to_pc", to_pc, 32'h300);
      chk("jal_no_clear", 32'(clear), 32'd0);

      // Fill 15 entries from tag 2; tail wraps 15 -> 1
      set_dispatch(OP_ADDI, 5'd10, 32'h120);
      for (int k = 1; k <= 15; k++) begin
         tick();
         if (k == 12) chk("fill_full_12", 32'(ROB_FULL), 32'd0);
         if (k == 13) chk("fill_full_13", 32'(ROB_FULL), 32'd1);
         if (k == 14) chk("fill_wrap_tag", 32'(ROB_next_tag), 32'd1);
      end
      dispatch_rdy = 1'b0;
      chk("fill_next_tag", 32'(ROB_next_tag), 32'd2);
      chk("fill_full", 32'(ROB_FULL), 32'd1);
      alu_wb(4'd2, 32'h22, 32'h120);
      lsb_wb(4'd3, 32'h33);
      tick();
      idle_inputs();
      set_dispatch(OP_ADDI, 5'd10, 32'h124);
      tick();
      dispatch_rdy = 1'b0;
      chk("full_commit", 32'(commit_pulse), 32'd1);
      chk("full_head_tag", 32'(head_tag), 32'd2);
      chk("full_write_val", write_val, 32'h22);
      chk("full_disp_tag", 32'(ROB_next_tag), 32'd3);
      tick();
      chk("full_c3_tag", 32'(head_tag), 32'd3);
      chk("full_c3_val", write_val, 32'h33);
      chk("full_c3_full", 32'(ROB_FULL), 32'd1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have parameter TAG_W, default 4, meaning ROB tag width; tag 0 means "no dependency".
REQ-002 SHALL have parameter ROB_SIZE, default 15, meaning usable entries, tags 1..15.
REQ-003 SHALL have parameter FULL_MARGIN, default 2, meaning free slots reserved for instructions in flight.
REQ-004 Ports, as name direction width meaning (clock and reset first):
- clk_in in 1: single clock.
- rst_in in 1: reset, asynchronous, active-low.
- rdy_in in 1: freeze all state when low.
- dispatch_rdy in 1: allocate an entry this cycle.
- up_inst in 32: dispatched instruction.
- up_npc in 32: predicted next PC (pc+4).
- up_rd in 5: destination register.
- rs1_rely, rs2_rely in TAG_W: operand producer tags.
- rs_rdy in 1: ALU result valid.
- rs_tag_bus in TAG_W: ALU result tag.
- up_alu_output in 32: ALU result.
- alu_npc in 32: resolved next PC.
- lsb_rdy in 1: LSB result valid.
- lsb_tag_bus in TAG_W: LSB result tag.
- up_lmd_output in 32: load data.
- ROB_next_tag out TAG_W: tail tag to assign.
- ROB_FULL out 1: stop fetch.
- ROB_rs1_valid / ROB_rs2_valid out 1: producer result available.
- ROB_rs1_ans_output / ROB_rs2_ans_output out 32: forwarded value.
- enable_write out 1: head is a store.
- enable_IO out 1: head is a load.
- write_rdy out 1: register commit.
- write_val out 32: commit value.
- to_rd out 5: commit register.
- head_tag out TAG_W: tag of the entry just committed.
- commit_pulse out 1: one pulse per commit.
- clear out 1: mispredict flush.
- to_pc out 32: committed next PC (redirect target when clear).

Function
REQ-005 Circular FIFO over tags 1..ROB_SIZE; pointers wrap ROB_SIZE->1 and never use 0.
REQ-006 Entry fields: busy, ready, op class (STORE 0100011, LOAD 0000011, BRANCH 1100011, JAL, JALR, OTHER from up_inst[6:0]), rd, predicted npc, value, actual npc.
REQ-007 dispatch_rdy allocates at tail with ready=0 and advances the tail; ROB_next_tag SHALL equal the tail pointer.
REQ-008 ROB_FULL SHALL be combinational and high when count >= ROB_SIZE-FULL_MARGIN.
REQ-009 rs_rdy SHALL write value=up_alu_output, actual npc=alu_npc and set ready; lsb_rdy SHALL write value=up_lmd_output and set ready (for stores, ready marks store completion).
REQ-010 Both writebacks and a dispatch in one cycle SHALL all be accepted.
REQ-011 Forwarding SHALL be combinational: valid=1 iff rely!=0 and (the entry is busy&ready, or a same-cycle rs_rdy/lsb_rdy tag matches, with the bus value taking priority); valid=0 otherwise.
REQ-012 enable_write = head busy & STORE & !ready; enable_IO = head busy & LOAD & !ready; both combinational.
REQ-013 When the head is busy&ready, the ROB SHALL commit one entry per cycle, registered:
- commit_pulse=1, head_tag=head tag, to_pc=actual npc (pc+4 for non-control ops).
- write_rdy=1 only if the op writes rd and rd!=0, with write_val/to_rd.
- Head advances.
REQ-014 JAL/JALR SHALL write value (link) to rd; stores and branches SHALL NOT write.
REQ-015 If a committing BRANCH/JAL/JALR has actual npc != predicted npc, next cycle clear=1 and to_pc=actual npc; all entries invalidated, head=tail=1, count=0.
REQ-016 In the clear cycle, dispatch and writebacks SHALL be ignored.
REQ-017 commit_pulse, write_rdy and clear SHALL be single-cycle pulses, 0 otherwise.
REQ-018 With rdy_in low, no state or registered output changes.
REQ-019 Commit and dispatch SHALL proceed together when the FIFO is full or empty.

Reset
REQ-020 rst_in low SHALL asynchronously set head=tail=1, count=0, all busy/ready=0, and all registered outputs 0; ROB_next_tag then reads 1.

Structure
REQ-021 Shared package rob_pkg SHALL hold TAG_W, ROB_SIZE, opcode constants, and the Addr/Inst/RegVal/Reg bus widths used by RS, LSB and regfile.
REQ-022 One sub-module, rob_op_class (opcode -> op class), SHALL be used; all else is in reorder_buffer.

Verification
REQ-023 Reset, dispatch ADDI rd=5; ALU writes tag1 value 7 -> next cycle write_rdy=1, to_rd=5, write_val=7, head_tag=1, commit_pulse=1.
REQ-024 Dispatch 15 entries without writeback -> ROB_FULL high from count 13; tail wraps 15->1 after commits.
REQ-025 rs1_rely=3 with rs_rdy tag3 value 0x55 in the same cycle -> ROB_rs1_valid=1, output 0x55; rely=0 -> valid=0.
REQ-026 Store at head -> enable_write=1 until lsb_rdy for its tag, then committed with no register write.
REQ-027 BRANCH with predicted npc 0x104 resolves alu_npc 0x200 -> clear=1, to_pc=0x200 next cycle; ROB_next_tag=1, younger entries discarded.
REQ-028 rdy_in low for 3 cycles with ready head -> no commit; commit occurs on the first cycle after rdy_in returns high.
